sram_port_arbiter: RTL and testbench



---
 rtl/mem_pkg.sv | 32 +++
 rtl/sram_rr_arb2.sv | 70 +++++++
 rtl/sram_port_arbiter.sv | 133 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the SRAM port arbiter.
//   MEM_ADDR_W / MEM_DATA_W : default word-address and data widths
//   req_id_e                : requester identity (m0 = CPU data, m1 = loader/DMA)
//   mem_req_t               : one memory command {byte enables, address, write data}
//   tag_t                   : response tag carried alongside a command
package mem_pkg;

  localparam int MEM_ADDR_W = 14;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_BE_W   = MEM_DATA_W / 8;

  typedef enum logic {
    REQ_M0 = 1'b0,
    REQ_M1 = 1'b1
  } req_id_e;

  typedef struct packed {
    logic [MEM_BE_W-1:0]   we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    req_id_e id;
    logic    is_read;
  } tag_t;

  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_M0) ? REQ_M1 : REQ_M0;
  endfunction

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-way round-robin arbiter with a bounded burst lock.
//   clk, rst : clock, asynchronous active-high reset
//   req[1:0] : request valid per requester (bit index = req_id_e)
//   lock[1:0]: requester wants to keep the grant across back-to-back requests
//   gnt[1:0] : one-hot (or zero) combinational grant
// Holds the round-robin pointer, last-cycle grantee (owner) and lock counter.
module sram_rr_arb2
  import mem_pkg::*;
#(
  parameter int LOCK_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  req_id_e          ptr;
  req_id_e          owner;
  logic             owner_vld;
  logic [CNT_W-1:0] lock_cnt;

  logic    lock_win;
  req_id_e win;

  // Lock override first, then a lone requester, then the pointer side.
  // A lone requester is granted even when its lock budget is spent.
  always_comb begin
    gnt      = '0;
    win      = ptr;
    lock_win = owner_vld && req[owner] && lock[owner] &&
               (lock_cnt < CNT_W'(LOCK_MAX));
    if (lock_win)               win = owner;
    else if (req[0] && !req[1]) win = REQ_M0;
    else if (req[1] && !req[0]) win = REQ_M1;
    if (|req) gnt[win] = 1'b1;
  end

  // lock_cnt counts consecutive locked grants to the same requester,
  // including the first one, so a locked burst is LOCK_MAX grants long.
  // Because the pointer always flips to the other side after a grant,
  // an exhausted lock hands over to the waiting requester automatically.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= REQ_M0;
      owner     <= REQ_M0;
      owner_vld <= 1'b0;
      lock_cnt  <= '0;
    end else begin
      owner_vld <= |req;
      if (|req) begin
        owner <= win;
        ptr   <= other_req(win);
        if (!lock[win])
          lock_cnt <= '0;
        else if (owner_vld && owner == win)
          lock_cnt <= (lock_cnt == CNT_W'(LOCK_MAX)) ? lock_cnt
                                                     : lock_cnt + CNT_W'(1);
        else
          lock_cnt <= CNT_W'(1);
      end else begin
        lock_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM port between m0 (CPU data) and m1 (boot loader / DMA).
//   clk, rst               : clock, asynchronous active-high reset
//   mX_req/we/addr/wdata   : command from requester X (we == 0 means read)
//   mX_lock                : request to hold the grant across a burst
//   mX_gnt                 : combinational accept
//   mX_rvalid / mX_rdata   : read response, two cycles after the grant
//   sram_cs/oe/web/addr/di : registered SRAM command pins (web active-low)
//   sram_do                : SRAM read data, valid the cycle after the command
// Pipeline: N = arbitrate, N+1 = command on pins, N+2 = read data returned.
module sram_port_arbiter
  import mem_pkg::*;
#(
  // mem_req_t is sized from the package, so width changes belong there.
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = MEM_DATA_W,
  parameter int LOCK_MAX = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic [DATA_W/8-1:0] m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic                m0_lock,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic [DATA_W/8-1:0] m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic                m1_lock,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                sram_cs,
  output logic                sram_oe,
  output logic [DATA_W/8-1:0] sram_web,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_di,
  input  logic [DATA_W-1:0]   sram_do
);

  localparam int RD_LAT = 2;

  logic [1:0] gnt;

  sram_rr_arb2 #(.LOCK_MAX(LOCK_MAX)) u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  ({m1_req, m0_req}),
    .lock ({m1_lock, m0_lock}),
    .gnt  (gnt)
  );

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  // Winning command mux.
  mem_req_t sel;
  req_id_e  sel_id;
  tag_t     cur_tag;

  always_comb begin
    sel_id = gnt[1] ? REQ_M1 : REQ_M0;
    if (gnt[1]) sel = {m1_we, m1_addr, m1_wdata};
    else        sel = {m0_we, m0_addr, m0_wdata};
    cur_tag.id      = sel_id;
    cur_tag.is_read = (sel.we == '0);
  end

  // Command stage. Address and write data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_cs   <= 1'b0;
      sram_oe   <= 1'b0;
      sram_web  <= '1;
      sram_addr <= '0;
      sram_di   <= '0;
    end else if (|gnt) begin
      sram_cs   <= 1'b1;
      sram_oe   <= cur_tag.is_read;
      sram_web  <= ~sel.we;
      sram_addr <= sel.addr;
      sram_di   <= sel.wdata;
    end else begin
      sram_cs   <= 1'b0;
      sram_oe   <= 1'b0;
      sram_web  <= '1;
    end
  end

  // Tag pipeline: slot 0 travels with the command, slot RD_LAT-1 lines up
  // with sram_do. Reset empties it so in-flight reads never respond.
  logic [RD_LAT-1:0] vld_pipe;
  tag_t [RD_LAT-1:0] tag_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[RD_LAT-2:0], |gnt};
      tag_pipe <= {tag_pipe[RD_LAT-2:0], cur_tag};
    end
  end

  tag_t rsp_tag;
  logic rsp_rd;

  assign rsp_tag   = tag_pipe[RD_LAT-1];
  assign rsp_rd    = vld_pipe[RD_LAT-1] && rsp_tag.is_read;
  assign m0_rvalid = rsp_rd && (rsp_tag.id == REQ_M0);
  assign m1_rvalid = rsp_rd && (rsp_tag.id == REQ_M1);

  // rdata passes sram_do straight through on its rvalid cycle and otherwise
  // shows the last value that requester received.
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (m0_rvalid) rdata0_q <= sram_do;
      if (m1_rvalid) rdata1_q <= sram_do;
    end
  end

  assign m0_rdata = m0_rvalid ? sram_do : rdata0_q;
  assign m1_rdata = m1_rvalid ? sram_do : rdata1_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: a small SRAM model, a table of directed
// per-cycle vectors, and hand-written lock / reset sequences.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req, m0_lock, m1_lock;
  logic [3:0]  m0_we, m1_we;
  logic [13:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        sram_cs, sram_oe;
  logic [3:0]  sram_web;
  logic [13:0] sram_addr;
  logic [31:0] sram_di, sram_do;

  always #5 clk = ~clk;

  sram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web),
    .sram_addr(sram_addr), .sram_di(sram_di), .sram_do(sram_do)
  );

  // SRAM model: registered read, byte-lane write, both on the command edge.
  logic [31:0] mem [16384];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] di,
                                        input logic [3:0] web);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (!web[b]) r[8*b +: 8] = di[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) sram_do <= '0;
    else if (sram_cs) begin
      if (sram_oe) sram_do <= mem[sram_addr];
      mem[sram_addr] <= merge(mem[sram_addr], sram_di, sram_web);
    end
  end

  int errors = 0;
  int checks = 0;
  int vi = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %h expected %h", nm, vi, act, exp);
    end
  endtask

  typedef struct packed {
    logic        rst;
    logic        m0_req; logic [3:0] m0_we; logic [13:0] m0_addr; logic [31:0] m0_wd;
    logic        m1_req; logic [3:0] m1_we; logic [13:0] m1_addr; logic [31:0] m1_wd;
    logic [1:0]  gnt;
    logic        cs;
    logic        oe;
    logic [3:0]  web;
    logic [13:0] addr;
    logic [1:0]  rv;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } vec_t;

  function automatic vec_t mk(
      input logic r, input logic q0, input logic [3:0] w0, input logic [13:0] a0, input logic [31:0] d0,
      input logic q1, input logic [3:0] w1, input logic [13:0] a1, input logic [31:0] d1,
      input logic [1:0] g, input logic cs, input logic oe, input logic [3:0] web,
      input logic [13:0] ad, input logic [1:0] rv, input logic [31:0] r0, input logic [31:0] r1);
    vec_t v;
    v = '{r, q0, w0, a0, d0, q1, w1, a1, d1, g, cs, oe, web, ad, rv, r0, r1};
    return v;
  endfunction

  localparam int NV = 21;
  vec_t tbl [NV];

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_lock = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_lock = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    //            rst m0:req we    addr   wdata          m1:req we    addr   wdata          gnt  cs oe web   addr   rv    rd0            rd1
    tbl[0]  = mk(1, 0, 4'h0, 14'h0,  32'h0,         0, 4'h0, 14'h0, 32'h0,         2'b00, 0, 0, 4'hF, 14'h0,  2'b00, 32'h0,         32'h0);
    tbl[1]  = mk(0, 1, 4'hF, 14'h10, 32'hDEADBEEF,  0, 4'h0, 14'h0, 32'h0,         2'b01, 0, 0, 4'hF, 14'h0,  2'b00, 32'h0,         32'h0);
    tbl[2]  = mk(0, 1, 4'h0, 14'h10, 32'h0,         0, 4'h0, 14'h0, 32'h0,         2'b01, 1, 0, 4'h0, 14'h10, 2'b00, 32'h0,         32'h0);
    tbl[3]  = mk(0, 0, 4'h0, 14'h0,  32'h0,         0, 4'h0, 14'h0, 32'h0,         2'b00, 1, 1, 4'hF, 14'h10, 2'b00, 32'h0,         32'h0);
    tbl[4]  = mk(0, 0, 4'h0, 14'h0,  32'h0,         0, 4'h0, 14'h0, 32'h0,         2'b00, 0, 0, 4'hF, 14'h10, 2'b01, 32'hDEADBEEF,  32'h0);
    tbl[5]  = mk(0, 1, 4'hF, 14'h1,  32'hA1A1A1A1,  0, 4'h0, 14'h0, 32'h0,         2'b01, 0, 0, 4'hF, 14'h10, 2'b00, 32'hDEADBEEF,  32'h0);
    tbl[6]  = mk(0, 0, 4'h0, 14'h0,  32'h0,         1, 4'hF, 14'h2, 32'hB2B2B2B2,  2'b10, 1, 0, 4'h0, 14'h1,  2'b00, 32'hDEADBEEF,  32'h0);
    tbl[7]  = mk(0, 1, 4'hF, 14'h3,  32'h11223344,  0, 4'h0, 14'h0, 32'h0,         2'b01, 1, 0, 4'h0, 14'h2,  2'b00, 32'hDEADBEEF,  32'h0);
    tbl[8]  = mk(0, 1, 4'h2, 14'h3,  32'h0000AA00,  0, 4'h0, 14'h0, 32'h0,         2'b01, 1, 0, 4'h0, 14'h3,  2'b00, 32'hDEADBEEF,  32'h0);
    tbl[9]  = mk(0, 1, 4'h0, 14'h3,  32'h0,         0, 4'h0, 14'h0, 32'h0,         2'b01, 1, 0, 4'hD, 14'h3,  2'b00, 32'hDEADBEEF,  32'h0);
    tbl[10] = mk(0, 0, 4'h0, 14'h0,  32'h0,         0, 4'h0, 14'h0, 32'h0,         2'b00, 1, 1, 4'hF, 14'h3,  2'b00, 32'hDEADBEEF,  32'h0);
    tbl[11] = mk(0, 0, 4'h0, 14'h0,  32'h0,         0, 4'h0, 14'h0, 32'h0,         2'b00, 0, 0, 4'hF, 14'h3,  2'b01, 32'h1122AA44,  32'h0);
    tbl[12] = mk(1, 0, 4'h0, 14'h0,  32'h0,         0, 4'h0, 14'h0, 32'h0,         2'b00, 0, 0, 4'hF, 14'h0,  2'b00, 32'h0,         32'h0);
    tbl[13] = mk(0, 1, 4'h0, 14'h1,  32'h0,         1, 4'h0, 14'h2, 32'h0,         2'b01, 0, 0, 4'hF, 14'h0,  2'b00, 32'h0,         32'h0);
    tbl[14] = mk(0, 1, 4'h0, 14'h1,  32'h0,         1, 4'h0, 14'h2, 32'h0,         2'b10, 1, 1, 4'hF, 14'h1,  2'b00, 32'h0,         32'h0);
    tbl[15] = mk(0, 1, 4'h0, 14'h1,  32'h0,         1, 4'h0, 14'h2, 32'h0,         2'b01, 1, 1, 4'hF, 14'h2,  2'b01, 32'hA1A1A1A1,  32'h0);
    tbl[16] = mk(0, 1, 4'h0, 14'h1,  32'h0,         1, 4'h0, 14'h2, 32'h0,         2'b10, 1, 1, 4'hF, 14'h1,  2'b10, 32'hA1A1A1A1,  32'hB2B2B2B2);
    tbl[17] = mk(0, 1, 4'h0, 14'h1,  32'h0,         1, 4'h0, 14'h2, 32'h0,         2'b01, 1, 1, 4'hF, 14'h2,  2'b01, 32'hA1A1A1A1,  32'hB2B2B2B2);
    tbl[18] = mk(0, 0, 4'h0, 14'h0,  32'h0,         0, 4'h0, 14'h0, 32'h0,         2'b00, 1, 1, 4'hF, 14'h1,  2'b10, 32'hA1A1A1A1,  32'hB2B2B2B2);
    tbl[19] = mk(0, 0, 4'h0, 14'h0,  32'h0,         0, 4'h0, 14'h0, 32'h0,         2'b00, 0, 0, 4'hF, 14'h1,  2'b01, 32'hA1A1A1A1,  32'hB2B2B2B2);
    tbl[20] = mk(0, 0, 4'h0, 14'h0,  32'h0,         0, 4'h0, 14'h0, 32'h0,         2'b00, 0, 0, 4'hF, 14'h1,  2'b00, 32'hA1A1A1A1,  32'hB2B2B2B2);

    for (int i = 0; i < NV; i++) begin
      next_cycle();
      vi = i;
      rst = tbl[i].rst;
      m0_req = tbl[i].m0_req; m0_we = tbl[i].m0_we; m0_addr = tbl[i].m0_addr; m0_wdata = tbl[i].m0_wd;
      m1_req = tbl[i].m1_req; m1_we = tbl[i].m1_we; m1_addr = tbl[i].m1_addr; m1_wdata = tbl[i].m1_wd;
      @(negedge clk);
      chk("gnt",       {m1_gnt, m0_gnt},       tbl[i].gnt);
      chk("sram_cs",   sram_cs,                tbl[i].cs);
      chk("sram_oe",   sram_oe,                tbl[i].oe);
      chk("sram_web",  sram_web,               tbl[i].web);
      chk("sram_addr", sram_addr,              tbl[i].addr);
      chk("rvalid",    {m1_rvalid, m0_rvalid}, tbl[i].rv);
      chk("m0_rdata",  m0_rdata,               tbl[i].rd0);
      chk("m1_rdata",  m1_rdata,               tbl[i].rd1);
    end

    // Reset one cycle after an m0 read grant: the read must never respond.
    vi = 100;
    next_cycle(); idle(); rst = 1;
    next_cycle(); rst = 0; m0_req = 1; m0_addr = 14'h1;
    @(negedge clk); chk("rst_seq_gnt", m0_gnt, 1'b1);
    next_cycle(); idle(); rst = 1;
    @(negedge clk);
    chk("rst_seq_cs", sram_cs, 1'b0);
    chk("rst_seq_web", sram_web, 4'hF);
    chk("rst_seq_rv", {m1_rvalid, m0_rvalid}, 2'b00);
    next_cycle(); rst = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk("rst_seq_no_rv", {m1_rvalid, m0_rvalid}, 2'b00);
      next_cycle();
    end
    m0_req = 1; m0_addr = 14'h1; m1_req = 1; m1_addr = 14'h2;
    @(negedge clk); chk("rst_seq_first", {m1_gnt, m0_gnt}, 2'b01);

    // Locked m1 burst with m0 waiting: 8 locked grants, one m0 grant, repeat.
    vi = 200;
    next_cycle(); idle(); rst = 1;
    for (int k = 0; k < 18; k++) begin
      next_cycle(); rst = 0;
      vi = 200 + k;
      m1_req = 1; m1_lock = 1; m1_addr = 14'h2;
      m0_req = (k >= 1); m0_addr = 14'h1;
      @(negedge clk);
      chk("lock_burst", {m1_gnt, m0_gnt}, (k == 8 || k == 17) ? 2'b01 : 2'b10);
    end

    // Lone locked requester is never forced to yield.
    vi = 300;
    next_cycle(); idle(); rst = 1;
    for (int k = 0; k < 20; k++) begin
      next_cycle(); rst = 0;
      vi = 300 + k;
      m0_req = 1; m0_lock = 1; m0_addr = 14'h5;
      @(negedge clk);
      chk("lone_lock", {m1_gnt, m0_gnt}, 2'b01);
    end

    next_cycle(); idle();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
